axis_frame_fifo: RTL and testbench

- Store-and-forward AXI4-Stream frame FIFO placed directly downstream of the stream multiplexer output.
- Buffers whole frames and releases a frame to the output only after its tlast beat is written and the frame is marked good.
- Bad frames (tuser[0] set on the tlast beat) and frames that cannot fit are discarded, so downstream consumers never see partial or errored frames.

---
 rtl/axis_frame_fifo.sv | 139 +++++++++++++
 tb/tb_axis_frame_fifo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI4-Stream frame FIFO: whole frames are buffered and only
// committed (made visible to the read side) once a good tlast beat is written.
module axis_frame_fifo #(
  parameter int DEPTH          = 4096,
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH     = (DATA_WIDTH / 8),
  parameter int USER_WIDTH     = 1,
  parameter int DROP_BAD_FRAME = 1,
  parameter int DROP_WHEN_FULL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int AW = $clog2(DEPTH) + 1;
  localparam int WW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
  localparam logic [AW-1:0] DEPTH_PTR = AW'(DEPTH);

  // Handshakes on both ports follow AXI4-Stream: a beat transfers on a rising
  // clk edge where tvalid and tready are both high; tvalid never waits on tready.

  logic [WW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_commit, wr_ptr_cur, rd_ptr, fetch_ptr;
  logic          drop_reg;
  logic          full, full_cur, empty;
  logic          s_hs, drop_beat;
  logic          pipe_valid, out_valid, pipe_ready, out_ready;
  logic [WW-1:0] pipe_data, out_data, wr_word;
  logic [KEEP_WIDTH-1:0] keep_in;

  // rd_ptr only advances on output handshakes, so words still held in the read
  // pipeline keep their slots reserved.
  assign full      = (wr_ptr_cur - rd_ptr) == DEPTH_PTR;
  assign full_cur  = (wr_ptr_cur - wr_ptr_commit) == DEPTH_PTR;
  assign empty     = fetch_ptr == wr_ptr_commit;

  assign s_axis_tready = !full || full_cur || drop_reg || (DROP_WHEN_FULL != 0);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign drop_beat     = drop_reg || full_cur || ((DROP_WHEN_FULL != 0) && full);

  assign keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign wr_word = {s_axis_tuser, s_axis_tlast, keep_in, s_axis_tdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_commit     <= '0;
      wr_ptr_cur        <= '0;
      drop_reg          <= 1'b0;
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      status_overflow   <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
      if (s_hs) begin
        if (drop_beat) begin
          if (s_axis_tlast) begin
            wr_ptr_cur      <= wr_ptr_commit;
            drop_reg        <= 1'b0;
            status_overflow <= 1'b1;
          end else begin
            drop_reg <= 1'b1;
          end
        end else if (s_axis_tlast) begin
          if ((DROP_BAD_FRAME != 0) && s_axis_tuser[0]) begin
            wr_ptr_cur       <= wr_ptr_commit;
            status_bad_frame <= 1'b1;
          end else begin
            wr_ptr_cur        <= wr_ptr_cur + 1'b1;
            wr_ptr_commit     <= wr_ptr_cur + 1'b1;
            status_good_frame <= 1'b1;
          end
        end else begin
          wr_ptr_cur <= wr_ptr_cur + 1'b1;
        end
      end
    end
  end

  // Two-stage read: registered memory read, then the output register.
  assign out_ready  = !out_valid || m_axis_tready;
  assign pipe_ready = !pipe_valid || out_ready;

  always_ff @(posedge clk) begin
    if (s_hs && !drop_beat) begin
      mem[wr_ptr_cur[AW-2:0]] <= wr_word;
    end
    if (pipe_ready && !empty) begin
      pipe_data <= mem[fetch_ptr[AW-2:0]];
    end
    if (out_ready) begin
      out_data <= pipe_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ptr  <= '0;
      rd_ptr     <= '0;
      pipe_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (pipe_ready) begin
        pipe_valid <= !empty;
        if (!empty) begin
          fetch_ptr <= fetch_ptr + 1'b1;
        end
      end
      if (out_ready) begin
        out_valid <= pipe_valid;
      end
      if (out_valid && m_axis_tready) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_data;
  assign m_axis_tvalid = out_valid;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo (DEPTH=16): stimulus pushes expected beats
// into a queue, an independent monitor pops and compares each output beat.
module tb_axis_frame_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic [0:0] s_tkeep;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic [0:0] s_tuser;
  logic [7:0] m_tdata;
  logic [0:0] m_tkeep;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic [0:0] m_tuser;
  logic       status_overflow, status_bad_frame, status_good_frame;

  int checks = 0;
  int errors = 0;
  int good_cnt = 0;
  int bad_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] exp_q[$];

  axis_frame_fifo #(
    .DEPTH(16), .DATA_WIDTH(8), .KEEP_ENABLE(0), .KEEP_WIDTH(1),
    .USER_WIDTH(1), .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .status_overflow(status_overflow), .status_bad_frame(status_bad_frame),
    .status_good_frame(status_good_frame)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word;
  initial begin
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(m_tvalid), 32'd1);
          check("stall_data", 32'({m_tuser, m_tlast, m_tdata}), 32'(prev_word));
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t",
                     {m_tuser, m_tlast, m_tdata}, $time);
          end else begin
            exp = exp_q.pop_front();
            check("out_beat", 32'({m_tuser, m_tlast, m_tdata}), 32'(exp));
            check("out_keep", 32'(m_tkeep), 32'd1);
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_word  = {m_tuser, m_tlast, m_tdata};
        if (status_good_frame) good_cnt++;
        if (status_bad_frame)  bad_cnt++;
        if (status_overflow)   ovf_cnt++;
      end
    end
  end

  // driver tasks
  task automatic send_beat(input logic [7:0] d, input logic last, input logic user,
                           output int waits);
    logic rdy;
    s_tdata  = d;
    s_tlast  = last;
    s_tuser  = user;
    s_tvalid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 300) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got no s_axis_tready, expected acceptance of 0x%0h", d);
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input logic bad, input logic expect_good,
                            output int waits);
    int w;
    waits = 0;
    if (expect_good)
      for (int i = 0; i < b.size(); i++)
        exp_q.push_back({1'b0, (i == b.size() - 1), b[i]});
    for (int i = 0; i < b.size(); i++) begin
      send_beat(b[i], (i == b.size() - 1), bad && (i == b.size() - 1), w);
      waits += w;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    checks++;
    errors++;
    $display("FAIL global_timeout: got no completion, expected end of stimulus");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] q[$];
    int waits;
    int g0, b0, o0;

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tuser = '0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_status", 32'({status_overflow, status_bad_frame, status_good_frame}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", 32'(s_tready), 32'd1);
    check("post_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;

    // 4-beat good frame and latency
    m_tready = 1'b1;
    g0 = good_cnt;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(q, 1'b0, 1'b1, waits);
    @(negedge clk);
    check("lat_edge0_valid", 32'(m_tvalid), 32'd0);
    check("good_pulse_on", 32'(status_good_frame), 32'd1);
    @(negedge clk);
    check("lat_edge1_valid", 32'(m_tvalid), 32'd0);
    check("good_pulse_off", 32'(status_good_frame), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(m_tvalid), 32'd1);
    drain("drain_frame1");
    check("good_cnt_frame1", 32'(good_cnt - g0), 32'd1);

    // bad frame dropped, then a good frame
    b0 = bad_cnt; g0 = good_cnt;
    q = '{8'h61, 8'h62, 8'h63};
    send_frame(q, 1'b1, 1'b0, waits);
    repeat (6) begin
      @(negedge clk);
      check("bad_no_valid", 32'(m_tvalid), 32'd0);
    end
    check("bad_cnt", 32'(bad_cnt - b0), 32'd1);
    check("bad_no_good", 32'(good_cnt - g0), 32'd0);
    @(posedge clk); #1;
    q = '{8'h71, 8'h72};
    send_frame(q, 1'b0, 1'b1, waits);
    drain("drain_after_bad");

    // 20-beat oversize frame
    o0 = ovf_cnt; g0 = good_cnt;
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'(8'h80 + i));
    send_frame(q, 1'b0, 1'b0, waits);
    check("oversize_no_wait", 32'(waits), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("oversize_no_valid", 32'(m_tvalid), 32'd0);
    end
    check("oversize_ovf_cnt", 32'(ovf_cnt - o0), 32'd1);
    check("oversize_no_good", 32'(good_cnt - g0), 32'd0);
    check("oversize_ready", 32'(s_tready), 32'd1);
    @(posedge clk); #1;

    // two 10-beat frames against a stalled output: full after 6 beats of the second
    m_tready = 1'b0;
    g0 = good_cnt;
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'(8'h30 + i));
    send_frame(q, 1'b0, 1'b1, waits);
    check("bp_frame_a_no_wait", 32'(waits), 32'd0);
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, (i == 9), 8'(8'h40 + i)});
    for (int i = 0; i < 6; i++) begin
      send_beat(8'(8'h40 + i), 1'b0, 1'b0, waits);
      check("bp_first6_no_wait", 32'(waits), 32'd0);
    end
    s_tvalid = 1'b1;
    s_tdata  = 8'h46;
    repeat (4) begin
      @(negedge clk);
      check("bp_full_ready_low", 32'(s_tready), 32'd0);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    for (int i = 6; i < 10; i++) send_beat(8'(8'h40 + i), (i == 9), 1'b0, waits);
    drain("drain_backpressure");
    check("bp_good_cnt", 32'(good_cnt - g0), 32'd2);

    // 1-beat frames with random output ready
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          q = '{8'(8'hA0 + i)};
          send_frame(q, 1'b0, 1'b1, waits);
        end
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_tready = 1'b1;
    drain("drain_random_ready");

    // committed frames stream without gaps once ready is held high
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q = '{8'(8'hB0 + i)};
      send_frame(q, 1'b0, 1'b1, waits);
    end
    repeat (5) @(posedge clk);
    #1;
    m_tready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_gap_valid", 32'(m_tvalid), 32'd1);
    end
    drain("drain_no_gap");

    // reset in the middle of a frame
    send_beat(8'hE1, 1'b0, 1'b0, waits);
    send_beat(8'hE2, 1'b0, 1'b0, waits);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q = '{8'h5A, 8'h5B};
    send_frame(q, 1'b0, 1'b1, waits);
    drain("drain_after_reset");
    repeat (10) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
